// File: rtl/tap_tempo_pkg.sv
// Shared constants and types for the tap-tempo step-clock source.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// TT_WIDTH is the width of the `speed` value consumed by the rate divider.
package tap_tempo_pkg;

   localparam int TT_WIDTH            = 28;
   localparam int TT_DEBOUNCE_CYC     = 500_000;      // 10 ms at 50 MHz
   localparam int TT_MIN_PERIOD       = 6_250_000;
   localparam int TT_MAX_PERIOD       = 100_000_000;
   localparam int TT_DEFAULT_PERIOD   = 25_000_000;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } tempo_state_e;

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF synchroniser, level debouncer and registered press pulse.
// Latency: press_o rises DEBOUNCE_CYC+3 cycles after a clean key_ni falling edge.
// Backpressure: none; press_o is a single-cycle event with no handshake.
// Ports: clk_i clock, rst_ni sync active-low reset, key_ni raw active-low key,
//        pressed_o debounced level (1 = pressed), press_o one-cycle press event.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic pressed_o,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;     // accepted raw level, 1 = released
   logic          prev_q;                 // stable_q one cycle ago
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q;

   // The counter measures how long the synchronised input has disagreed with
   // the accepted level; any agreement restarts the measurement.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
         stable_d = ~stable_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         prev_q   <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= key_ni;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         prev_q   <= stable_q;
         // released -> pressed only; a release produces no event
         press_q  <= prev_q & ~stable_q;
      end
   end

   assign pressed_o = ~stable_q;
   assign press_o   = press_q;

endmodule

// File: rtl/tap_tempo.sv
// Tap-tempo generator: measures tap intervals into a step period and emits a beat tick.
// Latency: period/locked update one cycle after the internal tap event (DEBOUNCE_CYC+4 after the key edge).
// Backpressure: none; beat_tick is a free-running single-cycle pulse.
// Ports: CLOCK_50 clock, resetn sync active-low reset, tap_n raw active-low key,
//        period step period in cycles, beat_tick one pulse per period, locked
//        set after the first accepted interval, tap_led debounced key (1 = pressed).
module tap_tempo
   import tap_tempo_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = TT_DEBOUNCE_CYC,
   parameter int MIN_PERIOD     = TT_MIN_PERIOD,
   parameter int MAX_PERIOD     = TT_MAX_PERIOD,
   parameter int DEFAULT_PERIOD = TT_DEFAULT_PERIOD,
   parameter int WIDTH          = TT_WIDTH
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             tap_n,
   output logic [WIDTH-1:0] period,
   output logic             beat_tick,
   output logic             locked,
   output logic             tap_led
);

   localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_PERIOD);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_PERIOD);
   localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_PERIOD);

   logic             tap;
   logic             pressed;
   tempo_state_e     state_q;
   logic [WIDTH-1:0] ivl_q;
   logic [WIDTH-1:0] period_q;
   logic             locked_q;
   logic [WIDTH-1:0] phase_q;
   logic             beat_q;

   logic [WIDTH-1:0] elapsed;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] avg;
   logic [WIDTH-1:0] period_m1;
   logic             accept;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_key (
      .clk_i     (CLOCK_50),
      .rst_ni    (resetn),
      .key_ni    (tap_n),
      .pressed_o (pressed),
      .press_o   (tap)
   );

   // ivl_q is cleared on the tap edge, so on the edge N cycles later it holds
   // N-1; elapsed = ivl_q + 1 is the true tap-to-tap distance.
   assign elapsed   = ivl_q + WIDTH'(1);
   assign sum       = {1'b0, period_q} + {1'b0, elapsed};
   assign avg       = sum[WIDTH:1];
   assign period_m1 = period_q - WIDTH'(1);
   assign accept    = (state_q == ST_MEASURE) && tap &&
                      (elapsed >= MIN_W) && (elapsed <= MAX_W);

   // Interval FSM. A tap at exactly MAX_PERIOD is accepted ahead of the timeout.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         ivl_q    <= '0;
         period_q <= DEF_W;
         locked_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tap) begin
                  state_q <= ST_MEASURE;
                  ivl_q   <= '0;
               end
            end
            ST_MEASURE: begin
               if (accept) begin
                  period_q <= locked_q ? avg : elapsed;
                  locked_q <= 1'b1;
                  ivl_q    <= '0;
               end else if (elapsed == MAX_W) begin
                  state_q <= ST_IDLE;
                  ivl_q   <= '0;
               end else begin
                  ivl_q <= elapsed;   // early taps fall through here and are ignored
               end
            end
         endcase
      end
   end

   // Beat generator, runs in both FSM states.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         phase_q <= '0;
         beat_q  <= 1'b0;
      end else if (accept) begin
         phase_q <= '0;               // re-align to the tap, no tick this cycle
         beat_q  <= 1'b0;
      end else if (phase_q == period_m1) begin
         phase_q <= '0;
         beat_q  <= 1'b1;
      end else if (phase_q > period_m1) begin
         phase_q <= '0;               // period shrank under the phase: wrap silently
         beat_q  <= 1'b0;
      end else begin
         phase_q <= phase_q + WIDTH'(1);
         beat_q  <= 1'b0;
      end
   end

   assign period    = period_q;
   assign locked    = locked_q;
   assign beat_tick = beat_q;
   assign tap_led   = pressed;

endmodule

// File: doc/tap_tempo.md
# tap_tempo

Tap-tempo generator feeding the sequencer's step clock. Debounces a raw push-button, measures the interval between successive presses and publishes a step period in `CLOCK_50` cycles, plus a free-running beat tick at that period. Sits upstream of the rate divider and replaces the fixed speed selector as the source of the 28-bit `speed` value.

## Interface
Parameters:
- `DEBOUNCE_CYC`, 500000: cycles the synchronised key must be stable before a level change is accepted (10 ms at 50 MHz).
- `MIN_PERIOD`, 6250000: shortest accepted tap interval in cycles.
- `MAX_PERIOD`, 100000000: longest interval; exceeding it times out.
- `DEFAULT_PERIOD`, 25000000: period after reset.
- `WIDTH`, 28: period/counter width.

Ports:
- `CLOCK_50` in 1: system clock; the only clock.
- `resetn` in 1: reset, synchronous and active-low.
- `tap_n` in 1: raw key input, active-low, asynchronous.
- `period` out WIDTH: current step period in cycles.
- `beat_tick` out 1: one-cycle pulse once per `period` cycles.
- `locked` out 1: high once at least one valid interval has been measured.
- `tap_led` out 1: debounced key state, 1 = pressed.

## Operation
- **Input path:**
  - `tap_n` passes through a 2-FF synchroniser.
  - The debouncer holds a stable level and a counter. The counter clears whenever the synchronised input equals the stable level. When the input differs for `DEBOUNCE_CYC` consecutive cycles, the stable level flips.
  - A stable transition released→pressed produces a one-cycle `tap` event. Release produces nothing.
- **FSM states:** IDLE, MEASURE. An interval counter `ivl` (WIDTH bits) runs only in MEASURE and increments by 1 per cycle.
- **IDLE:**
  - On `tap`: go to MEASURE with `ivl` = 0.
  - `period` and `locked` are unchanged.
- **MEASURE, `tap` with `ivl` < `MIN_PERIOD`:**
  - The tap is ignored and `ivl` keeps counting.
- **MEASURE, `tap` with `MIN_PERIOD` ≤ `ivl` ≤ `MAX_PERIOD`:** the tap is accepted.
  - If `locked` = 0: `period` ← `ivl`.
  - Else: `period` ← (`period` + `ivl`) >> 1. The sum is computed in WIDTH+1 bits and truncates toward zero.
  - `locked` ← 1; `ivl` ← 0; beat phase ← 0. Stay in MEASURE.
- **MEASURE, timeout:** when `ivl` reaches `MAX_PERIOD` with no tap, go to IDLE. `period` and `locked` are retained.
- **Simultaneous tap and timeout (`ivl` == `MAX_PERIOD`):** the tap wins and is accepted.
- **Beat generator:**
  - `phase` counts 0..`period`−1.
  - When `phase` == `period`−1: `beat_tick` = 1 and `phase` ← 0.
  - If `period` shrinks below the current `phase`, `phase` wraps to 0 on the next cycle with no tick.
  - An accepted tap resets `phase` to 0 in the same cycle without emitting a tick.
  - The beat generator runs in both FSM states.
- **Reset values:** `period` = `DEFAULT_PERIOD`, `locked` = 0, `beat_tick` = 0, `tap_led` = 0, FSM = IDLE, `ivl` = 0, `phase` = 0. Debouncer stable level = released, debounce counter = 0. Synchroniser flops are set to 1 (released).

## Timing
- **Press to `tap`:** 2 synchroniser cycles + `DEBOUNCE_CYC` stable cycles. `tap` is registered, giving fixed latency `DEBOUNCE_CYC`+3 cycles from the `tap_n` edge.
- **Outputs:** `period` and `locked` update on the clock edge after the `tap` cycle.
- **`beat_tick`:** registered; a tick is never adjacent to another tick unless `period` = 1.
- **Reset mid-operation:** all state returns to reset values on the first edge with `resetn` = 0. A press held through reset release must complete a full debounce before it registers.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, MEASURE);
  - `WIDTH`;
  - default period constants, so the top level and rate divider agree on the `speed` width.
- Sub-module `key_debounce` (synchroniser + debouncer + press-edge pulse) is reusable for the reset/load keys. `tap_tempo` instantiates it once.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `MIN_PERIOD`=100, `MAX_PERIOD`=1000, `DEFAULT_PERIOD`=500.
- **Reset:** hold `resetn`=0 for 3 cycles → `period`=500, `locked`=0, `tap_led`=0. Then `beat_tick` pulses every 500 cycles.
- **Bounce:** toggle `tap_n` every 2 cycles for 20 cycles, then settle high → no `tap`, `tap_led` stays 0.
- **First interval:** clean presses 300 cycles apart → `period`=300 and `locked`=1 one cycle after the second `tap`. Next `beat_tick` 300 cycles after that `tap`.
- **Averaging:** then a press 401 cycles later → `period`=(300+401)>>1=350.
- **Too short:** a press 50 cycles after an accepted tap → ignored, `period` unchanged. A following press 250 cycles after the accepted tap → accepted with `ivl`=250.
- **Timeout:** no press for 1001 cycles after a tap → FSM returns to IDLE and `period` is retained. The next press only restarts measurement, and the press after it (e.g. 200 cycles later) sets `period`=(old+200)>>1.
